// File: rtl/mc_ctrl_fsm_pkg.sv
// Shared encodings for the multicycle control unit: FSM states, MIPS
// opcode/funct fields, ALU operation codes and ALU operand-B selects.
package mc_ctrl_fsm_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_RTYPEEX,
    S_RTYPEWB,
    S_BRANCH,
    S_ADDIEX,
    S_ADDIWB,
    S_JUMP
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [2:0] SRCB_B      = 3'b000;
  localparam logic [2:0] SRCB_FOUR   = 3'b001;
  localparam logic [2:0] SRCB_INST   = 3'b010;
  localparam logic [2:0] SRCB_SEXTSH = 3'b011;
  localparam logic [2:0] SRCB_SEXT   = 3'b100;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_ctrl_fsm_aludec.sv
// R-type funct decoder: maps funct to an ALU operation, flags unknown functs.
module ctrl_aludec
  import mc_ctrl_fsm_pkg::*;
#(
  parameter int unsigned FN_W = 6
) (
  input  logic [FN_W-1:0] funct_i,
  output logic [2:0]      alucont_o,
  output logic            illegal_o
);

  // Unknown functs fall back to add so the datapath still sees a defined op.
  always_comb begin
    alucont_o = ALU_ADD;
    illegal_o = 1'b0;
    case (funct_i)
      FN_ADD:  alucont_o = ALU_ADD;
      FN_SUB:  alucont_o = ALU_SUB;
      FN_AND:  alucont_o = ALU_AND;
      FN_OR:   alucont_o = ALU_OR;
      FN_SLT:  alucont_o = ALU_SLT;
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS-subset control FSM (fetch/decode/execute/memory/writeback).
// Optional performance counters are enabled with the CTRL_PERF_CNT_EN macro.
module mc_ctrl_fsm
  import mc_ctrl_fsm_pkg::*;
#(
  parameter int unsigned OP_W = 6,
  parameter int unsigned FN_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [OP_W-1:0] op_i,
  input  logic [FN_W-1:0] funct_i,
  input  logic            zero_i,
  input  logic            mem_ready_i,
  output logic            memread_o,
  output logic            memwrite_o,
  output logic            irwrite_o,
  output logic            pcen_o,
  output logic            iord_o,
  output logic            alusrca_o,
  output logic [2:0]      alusrcb_o,
  output logic [2:0]      alucont_o,
  output logic [1:0]      pcsource_o,
  output logic            regwrite_o,
  output logic            regdst_o,
  output logic            memtoreg_o,
  output logic            bne_o,
  output logic            j_o,
  output logic            illegal_o
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [31:0]     cycle_cnt_o,
  output logic [31:0]     instret_cnt_o
`endif
);

  state_e     state_q, state_d;
  logic       memread, memwrite, irwrite, pcen, regwrite;
  logic [2:0] dec_alucont;
  logic       dec_illegal;

  ctrl_aludec #(.FN_W(FN_W)) u_aludec (
    .funct_i  (funct_i),
    .alucont_o(dec_alucont),
    .illegal_o(dec_illegal)
  );

  // State register; reset restarts the sequence at FETCH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_FETCH;
    else      state_q <= state_d;
  end

  // Next-state and per-state control outputs.
  always_comb begin
    state_d    = state_q;
    memread    = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    pcen       = 1'b0;
    regwrite   = 1'b0;
    iord_o     = 1'b0;
    alusrca_o  = 1'b0;
    alusrcb_o  = SRCB_B;
    alucont_o  = ALU_AND;
    pcsource_o = PCSRC_ALU;
    regdst_o   = 1'b0;
    memtoreg_o = 1'b0;
    bne_o      = 1'b0;
    j_o        = 1'b0;
    illegal_o  = 1'b0;
    case (state_q)
      S_FETCH: begin
        memread   = 1'b1;
        alusrcb_o = SRCB_FOUR;
        alucont_o = ALU_ADD;
        irwrite   = mem_ready_i;
        pcen      = mem_ready_i;
        if (mem_ready_i) state_d = S_DECODE;
      end
      S_DECODE: begin
        alusrcb_o = SRCB_SEXTSH;
        alucont_o = ALU_ADD;
        case (op_i)
          OP_LW, OP_SW:   state_d = S_MEMADR;
          OP_RTYPE:       state_d = S_RTYPEEX;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_ADDI:        state_d = S_ADDIEX;
          OP_J:           state_d = S_JUMP;
          default: begin
            illegal_o = 1'b1;
            state_d   = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca_o = 1'b1;
        alusrcb_o = SRCB_SEXT;
        alucont_o = ALU_ADD;
        state_d   = (op_i == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        iord_o  = 1'b1;
        memread = 1'b1;
        if (mem_ready_i) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        regwrite   = 1'b1;
        memtoreg_o = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        iord_o   = 1'b1;
        memwrite = 1'b1;
        if (mem_ready_i) state_d = S_FETCH;
      end
      S_RTYPEEX: begin
        alusrca_o = 1'b1;
        alucont_o = dec_alucont;
        illegal_o = dec_illegal;
        state_d   = S_RTYPEWB;
      end
      S_RTYPEWB: begin
        regwrite = 1'b1;
        regdst_o = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        alusrca_o  = 1'b1;
        alucont_o  = ALU_SUB;
        pcsource_o = PCSRC_ALUOUT;
        bne_o      = (op_i == OP_BNE);
        pcen       = zero_i ^ (op_i == OP_BNE);
        state_d    = S_FETCH;
      end
      S_ADDIEX: begin
        alusrca_o = 1'b1;
        alusrcb_o = SRCB_SEXT;
        alucont_o = ALU_ADD;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: begin
        regwrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_JUMP: begin
        pcsource_o = PCSRC_JUMP;
        j_o        = 1'b1;
        pcen       = 1'b1;
        state_d    = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Strobes are masked by reset so an in-flight write is killed without a clock edge.
  assign memread_o  = memread  & rst;
  assign memwrite_o = memwrite & rst;
  assign irwrite_o  = irwrite  & rst;
  assign pcen_o     = pcen     & rst;
  assign regwrite_o = regwrite & rst;

`ifdef CTRL_PERF_CNT_EN
  logic [31:0] cycle_q, instret_q;

  // Cycle counter runs every clock out of reset; instret counts returns to
  // FETCH from any terminal state (DECODE returns are illegal-opcode aborts).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      cycle_q <= cycle_q + 32'd1;
      if (state_d == S_FETCH && state_q != S_FETCH && state_q != S_DECODE)
        instret_q <= instret_q + 32'd1;
    end
  end

  assign cycle_cnt_o   = cycle_q;
  assign instret_cnt_o = instret_q;
`endif

endmodule
